// File: rtl/conv_cmd_sequencer.sv
// Host command sequencer between the conv image memory and its address FSM (load / process / readback).
// Optional macro CMD_TIMEOUT_EN adds an idle-cycle watchdog that aborts stalled commands.
module conv_cmd_sequencer #(
    parameter int NB_DATA  = 8,
    parameter int NB_IMAGE = 10,
    parameter int RD_LAT   = 2,
    parameter int TIMEOUT  = 1023
) (
    input  logic                i_CLK,
    input  logic                i_reset,
    input  logic [1:0]          i_cmd,
    input  logic                i_cmd_vld,
    input  logic [NB_IMAGE-1:0] i_imgLength,
    input  logic [NB_DATA-1:0]  i_data,
    input  logic                i_data_vld,
    output logic                o_data_rdy,
    input  logic [NB_DATA-1:0]  i_mem_data,
    output logic [NB_DATA-1:0]  o_rd_data,
    output logic                o_rd_vld,
    input  logic                i_rd_rdy,
    input  logic                i_changeBlock,
    input  logic                i_EoP,
    output logic                o_load,
    output logic                o_SoP,
    output logic                o_valid,
    output logic [NB_DATA-1:0]  o_data,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_cmd_err,
    output logic                o_timeout
);
    // state      | meaning
    // IDLE       | waiting for a host command
    // LOAD       | host pixels written to memory, one o_valid step per pixel
    // PROC       | address FSM processing, o_SoP held high
    // READ_ISSUE | issue one memory read step
    // READ_WAIT  | wait RD_LAT cycles for memory data
    // READ_HOLD  | readback word offered to host until accepted
    // FINISH     | o_done pulse, back to IDLE
    typedef enum logic [2:0] {
        IDLE, LOAD, PROC, READ_ISSUE, READ_WAIT, READ_HOLD, FINISH
    } state_t;

    localparam int LAT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

    state_t              state, state_next;
    logic                cb_q, cb_rise, cb_seen;
    logic                valid_q;
    logic [LAT_W-1:0]    lat_cnt;
    logic [NB_IMAGE-1:0] img_len_unused;
    logic                valid_set, err_set, data_take, rd_take, rd_capture;

`ifdef CMD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt;
    logic            to_activity, to_fire;
`endif

    assign cb_rise    = i_changeBlock & ~cb_q;
    assign o_busy     = (state != IDLE);
    assign o_load     = (state == LOAD);
    assign o_SoP      = (state == PROC);
    assign o_done     = (state == FINISH);
    // a new pixel is only taken when the resulting pulse keeps a low cycle after the last one
    assign o_data_rdy = (state == LOAD) & ~o_valid & ~valid_q & ~cb_rise;
    assign data_take  = i_data_vld & o_data_rdy;
    assign rd_take    = o_rd_vld & i_rd_rdy;
    assign rd_capture = (state == READ_WAIT) && (lat_cnt == '0);

    always_comb begin
        state_next = state;
        valid_set  = 1'b0;
        err_set    = i_cmd_vld && (state != IDLE);
        case (state)
            IDLE: begin
                if (i_cmd_vld) begin
                    case (i_cmd)
                        2'b01:   state_next = LOAD;
                        2'b10:   state_next = PROC;
                        2'b11: begin
                            if (i_EoP) state_next = READ_ISSUE;
                            else       err_set    = 1'b1;
                        end
                        default: err_set = 1'b1;
                    endcase
                end
            end
            LOAD: begin
                valid_set = data_take;
                if (cb_rise) state_next = FINISH;
            end
            PROC: begin
                if (cb_rise) state_next = FINISH;
            end
            READ_ISSUE: begin
                if (cb_rise || cb_seen) begin
                    state_next = FINISH;
                end else begin
                    valid_set  = 1'b1;
                    state_next = READ_WAIT;
                end
            end
            READ_WAIT: begin
                if (rd_capture) state_next = READ_HOLD;
            end
            READ_HOLD: begin
                if (rd_take) state_next = (cb_rise || cb_seen) ? FINISH : READ_ISSUE;
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
`ifdef CMD_TIMEOUT_EN
        to_activity = o_valid | data_take | rd_take | (state_next != state);
        to_fire     = (state != IDLE) && !to_activity && (to_cnt == TO_W'(1));
        if (to_fire) begin
            state_next = IDLE;
            err_set    = 1'b1;
        end
`endif
    end

    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            state          <= IDLE;
            cb_q           <= 1'b0;
            cb_seen        <= 1'b0;
            o_valid        <= 1'b0;
            valid_q        <= 1'b0;
            lat_cnt        <= '0;
            o_data         <= '0;
            o_rd_data      <= '0;
            o_rd_vld       <= 1'b0;
            o_cmd_err      <= 1'b0;
            img_len_unused <= '0;
        end else begin
            state     <= state_next;
            cb_q      <= i_changeBlock;
            o_valid   <= valid_set;
            valid_q   <= o_valid;
            o_cmd_err <= err_set;
            if (state == IDLE)  cb_seen <= 1'b0;
            else if (cb_rise)   cb_seen <= 1'b1;
            // length is owned by the address FSM; kept here only as the accept-time snapshot
            if (i_cmd_vld && state == IDLE) img_len_unused <= i_imgLength;
            if (data_take) o_data <= i_data;
            if (state == READ_ISSUE)
                lat_cnt <= LAT_W'(RD_LAT);
            else if (state == READ_WAIT && lat_cnt != '0)
                lat_cnt <= lat_cnt - LAT_W'(1);
            if (rd_capture) begin
                o_rd_data <= i_mem_data;
                o_rd_vld  <= 1'b1;
            end else if (rd_take || state_next == IDLE) begin
                o_rd_vld  <= 1'b0;
            end
        end
    end

`ifdef CMD_TIMEOUT_EN
    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            to_cnt    <= TO_W'(TIMEOUT);
            o_timeout <= 1'b0;
        end else begin
            if (state == IDLE || to_activity) to_cnt <= TO_W'(TIMEOUT);
            else                              to_cnt <= to_cnt - TO_W'(1);
            if (to_fire) o_timeout <= 1'b1;
        end
    end
`else
    localparam int TIMEOUT_UNUSED = TIMEOUT;
    assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_conv_cmd_sequencer.sv
// Directed bench for conv_cmd_sequencer: load, process, readback, command errors, reset and timeout.
module tb_conv_cmd_sequencer;
    localparam int NB_DATA  = 8;
    localparam int NB_IMAGE = 10;
    localparam int RD_LAT   = 2;
    localparam int TIMEOUT  = 16;

    logic                i_CLK = 1'b0;
    logic                i_reset;
    logic [1:0]          i_cmd;
    logic                i_cmd_vld;
    logic [NB_IMAGE-1:0] i_imgLength;
    logic [NB_DATA-1:0]  i_data;
    logic                i_data_vld;
    logic                o_data_rdy;
    logic [NB_DATA-1:0]  i_mem_data;
    logic [NB_DATA-1:0]  o_rd_data;
    logic                o_rd_vld;
    logic                i_rd_rdy;
    logic                i_changeBlock;
    logic                i_EoP;
    logic                o_load, o_SoP, o_valid, o_busy, o_done, o_cmd_err, o_timeout;
    logic [NB_DATA-1:0]  o_data;

    conv_cmd_sequencer #(
        .NB_DATA(NB_DATA), .NB_IMAGE(NB_IMAGE), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_CLK(i_CLK), .i_reset(i_reset), .i_cmd(i_cmd), .i_cmd_vld(i_cmd_vld),
        .i_imgLength(i_imgLength), .i_data(i_data), .i_data_vld(i_data_vld),
        .o_data_rdy(o_data_rdy), .i_mem_data(i_mem_data), .o_rd_data(o_rd_data),
        .o_rd_vld(o_rd_vld), .i_rd_rdy(i_rd_rdy), .i_changeBlock(i_changeBlock),
        .i_EoP(i_EoP), .o_load(o_load), .o_SoP(o_SoP), .o_valid(o_valid),
        .o_data(o_data), .o_busy(o_busy), .o_done(o_done), .o_cmd_err(o_cmd_err),
        .o_timeout(o_timeout)
    );

    always #5 i_CLK = ~i_CLK;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rd_q[$];

    task automatic step();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_flags"}, 32'({o_busy, o_load, o_SoP, o_valid, o_data_rdy, o_rd_vld,
                                    o_done, o_cmd_err, o_timeout}), 32'd0);
        check({tag, "_o_data"}, 32'(o_data), 32'd0);
        check({tag, "_o_rd_data"}, 32'(o_rd_data), 32'd0);
    endtask

    task automatic send_cmd(input logic [1:0] cmd);
        i_cmd     = cmd;
        i_cmd_vld = 1'b1;
        step();
        i_cmd_vld = 1'b0;
        i_cmd     = 2'b00;
    endtask

    // memory model: word for the k-th read step is valid exactly RD_LAT cycles after its o_valid
    int         mem_cnt = 0;
    logic [7:0] mem_idx = 8'd0;
    always begin
        step();
        i_mem_data = 8'hEE;
        if (o_valid && !o_load) begin
            mem_cnt = RD_LAT;
        end else if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                i_mem_data = 8'(8'hA0 + mem_idx);
                rd_q.push_back(i_mem_data);
                mem_idx++;
            end
        end
    end

    initial begin
        int   pulses, words, sop_cnt, hold, bad, bad_hold, p5_at, done_at, busy_cyc;
        logic prev_valid, done_seen;
        i_reset = 1'b1; i_cmd = 2'b00; i_cmd_vld = 1'b0; i_imgLength = '0;
        i_data = '0; i_data_vld = 1'b0; i_mem_data = 8'hEE; i_rd_rdy = 1'b0;
        i_changeBlock = 1'b0; i_EoP = 1'b0;
        step(); step();
        check_zero("reset");
        i_reset = 1'b0;
        step();

        // rejected commands in IDLE
        send_cmd(2'b11);
        check("rd_no_eop_err", 32'(o_cmd_err), 32'd1);
        check("rd_no_eop_idle", 32'(o_busy), 32'd0);
        step();
        check("err_one_cycle", 32'(o_cmd_err), 32'd0);
        send_cmd(2'b00);
        check("cmd_none_err", 32'(o_cmd_err), 32'd1);
        step();

        // load: 5 pixels, changeBlock raised on the 5th pulse
        i_imgLength = 10'd4;
        send_cmd(2'b01);
        check("load_level", 32'({o_busy, o_load, o_SoP}), 32'b110);
        pulses = 0; words = 0; bad = 0; p5_at = -1; done_at = -1;
        done_seen = 1'b0; prev_valid = 1'b0;
        for (int c = 0; c < 60 && !done_seen; c++) begin
            if (o_valid) begin
                if (prev_valid) bad++;
                pulses++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $error("FAIL load_sb_empty: observed pulse %0d required no pulse", pulses);
                end else begin
                    check("load_data", 32'(o_data), 32'(exp_q.pop_front()));
                end
                if (pulses == 5) begin
                    i_changeBlock = 1'b1;
                    p5_at = c;
                end
            end
            if (o_done) begin
                done_seen = 1'b1;
                done_at = c;
            end
            prev_valid = o_valid;
            #1;
            if (o_data_rdy && words < 5) begin
                i_data = 8'(8'h11 + words);
                i_data_vld = 1'b1;
                exp_q.push_back(i_data);
                words++;
            end else begin
                i_data_vld = 1'b0;
            end
            step();
        end
        i_data_vld = 1'b0;
        check("load_pulses", pulses, 5);
        check("load_pulse_gap", bad, 0);
        check("load_done_lat", done_at - p5_at, 1);
        check("load_idle_after", 32'({o_busy, o_done}), 32'd0);

        // process: changeBlock still high from load must not count again
        send_cmd(2'b10);
        sop_cnt = 0; bad = 0; done_seen = 1'b0;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            if (o_valid) bad++;
            if (o_done) begin
                done_seen = 1'b1;
                check("proc_sop_off_at_done", 32'(o_SoP), 32'd0);
            end
            if (o_SoP) sop_cnt++;
            if (o_SoP && sop_cnt == 3)
                check("busy_cmd_err", 32'({o_cmd_err, o_load, o_SoP}), 32'b101);
            if (o_SoP && sop_cnt == 2) begin
                i_cmd = 2'b01;
                i_cmd_vld = 1'b1;
            end else begin
                i_cmd_vld = 1'b0;
            end
            if (sop_cnt == 4) i_changeBlock = 1'b0;
            if (sop_cnt == 9) i_changeBlock = 1'b1;
            step();
        end
        check("proc_sop_cycles", sop_cnt, 9);
        check("proc_no_valid", bad, 0);
        check("proc_done", 32'(done_seen), 32'd1);
        i_changeBlock = 1'b0;
        step();

        // readback: host stalls 3 cycles per word, block ends during 3rd word
        i_EoP = 1'b1;
        send_cmd(2'b11);
        pulses = 0; words = 0; hold = 0; bad = 0; bad_hold = 0; done_seen = 1'b0;
        for (int c = 0; c < 80 && !done_seen; c++) begin
            if (o_valid) begin
                pulses++;
                if (o_rd_vld) bad++;
            end
            if (o_done) done_seen = 1'b1;
            i_rd_rdy = 1'b0;
            if (o_rd_vld) begin
                hold++;
                if (hold == 1) begin
                    words++;
                    if (rd_q.size() == 0) begin
                        miscompares++;
                        $error("FAIL rd_sb_empty: observed word %0d required none", words);
                    end else begin
                        check("rd_data", 32'(o_rd_data), 32'(rd_q.pop_front()));
                    end
                    if (words == 3) i_changeBlock = 1'b1;
                end
                if (hold == 4) begin
                    i_rd_rdy = 1'b1;
                    hold = 0;
                end
            end else if (hold != 0) begin
                bad_hold++;
                hold = 0;
            end
            step();
        end
        i_rd_rdy = 1'b0;
        i_changeBlock = 1'b0;
        check("rd_words", words, 3);
        check("rd_pulses", pulses, 3);
        check("rd_valid_during_hold", bad, 0);
        check("rd_vld_held", bad_hold, 0);
        check("rd_done", 32'(done_seen), 32'd1);
        check("rd_data_kept", 32'(o_rd_data), 32'hA2);
        step();

        // reset in the middle of a load after two pulses
        send_cmd(2'b01);
        pulses = 0; words = 0;
        for (int c = 0; c < 40 && pulses < 2; c++) begin
            if (o_valid) pulses++;
            if (pulses < 2 && o_data_rdy) begin
                i_data = 8'(8'h31 + words);
                i_data_vld = 1'b1;
                words++;
            end else begin
                i_data_vld = 1'b0;
            end
            if (pulses < 2) step();
        end
        check("rst_pulses_before", pulses, 2);
        i_data_vld = 1'b0;
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        check_zero("mid_load_reset");
        done_seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (o_done || o_busy) done_seen = 1'b1;
            step();
        end
        check("rst_no_done", 32'(done_seen), 32'd0);

        // host stalls in LOAD
        send_cmd(2'b01);
`ifdef CMD_TIMEOUT_EN
        busy_cyc = 0;
        for (int c = 0; c < 60 && o_busy; c++) begin
            busy_cyc++;
            step();
        end
        check("to_busy_cycles", busy_cyc, TIMEOUT);
        check("to_err", 32'({o_cmd_err, o_timeout, o_busy}), 32'b110);
        step(); step(); step();
        check("to_sticky", 32'({o_cmd_err, o_timeout}), 32'b01);
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        check("to_cleared", 32'(o_timeout), 32'd0);
`else
        busy_cyc = 0;
        for (int c = 0; c < 40; c++) begin
            if (o_busy) busy_cyc++;
            step();
        end
        check("stall_busy", busy_cyc, 40);
        check("stall_no_timeout", 32'({o_load, o_timeout, o_cmd_err}), 32'b100);
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        check("stall_reset", 32'(o_busy), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
